lfsr_checker: RTL
=================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter MAX_PIXEL_BITS, default from shared parameters header, word width; SHALL be >= 13 (taps at bits 12 and 3).
REQ-002 Parameter CNT_W, default 16, width of error and word counters.
REQ-003 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 nreset_i  in  1  reset, synchronous, active-low.
REQ-005 config_i  in  1  config target select: 0 = seed register, 1 = stop register.
REQ-006 config_rdy_i  in  1  config write strobe.
REQ-007 config_data_i  in  MAX_PIXEL_BITS  config write data.
REQ-008 config_done_o  out  1  config acknowledge, registered copy of config_rdy_i.
REQ-009 config_data_o  out  MAX_PIXEL_BITS  readback: stop register if config_i=1, else seed register.
REQ-010 chk_en_i  in  1  start/hold check; deassertion aborts.
REQ-011 data_vld_i  in  1  received word valid.
REQ-012 data_i  in  MAX_PIXEL_BITS  received pseudo-random word.
REQ-013 chk_busy_o  out  1  high in RUN.
REQ-014 chk_done_o  out  1  high in DONE.
REQ-015 chk_pass_o  out  1  high in DONE when err_cnt_o == 0.
REQ-016 err_cnt_o  out  CNT_W  mismatch count.
REQ-017 word_cnt_o  out  CNT_W  valid words checked.

Function
REQ-018 next(x) SHALL equal {x[MAX_PIXEL_BITS-2:0], ~(x[12]^x[3])}.
REQ-019 Config write: config_rdy_i=1 SHALL load config_data_i into seed (config_i=0) or stop (config_i=1) next edge; config_done_o SHALL follow config_rdy_i by one cycle; writes accepted in every state.
REQ-020 FSM states IDLE, RUN, DONE.
REQ-021 IDLE: exp register SHALL track seed each cycle; on chk_en_i=1, counters SHALL clear and state SHALL go to DONE if seed == stop, else RUN with exp = next(seed).
REQ-022 RUN, data_vld_i=1: data_i != exp SHALL increment err_cnt_o; word_cnt_o SHALL increment; exp SHALL load next(exp).
REQ-023 RUN, data_vld_i=1 and exp == stop: state SHALL go to DONE after the compare (termination on expected value, independent of data_i).
REQ-024 RUN, data_vld_i=0: no state change except abort.
REQ-025 Both counters SHALL saturate at 2^CNT_W-1.
REQ-026 chk_en_i=0 in RUN or DONE SHALL return to IDLE next edge; counters SHALL hold until next start; abort has priority over a same-cycle valid word (word not counted).
REQ-027 DONE: outputs held; data_vld_i ignored.
REQ-028 Outputs SHALL be registered; compare result visible on err_cnt_o one cycle after the valid word.

Reset
REQ-029 nreset_i=0 at an edge SHALL force IDLE, seed=0, stop=0, exp=0, counters=0, config_done_o=0, all status outputs 0, including mid-RUN.

Configuration
REQ-030 Macro LFSR_CHK_ERRCAP_EN defined: SHALL add outputs err_exp_o and err_act_o (MAX_PIXEL_BITS) and err_seen_o (1), capturing exp and data_i of the first mismatch after start, cleared on start and reset.
REQ-031 Macro undefined: those ports and registers SHALL not exist; all other behaviour identical.

Structure
REQ-032 FSM state enum and next() tap indices SHALL live in the shared package next to MAX_PIXEL_BITS.
REQ-033 Sub-module lfsr_chk_cfg SHALL hold seed/stop registers, config_done_o and readback.

Verification (MAX_PIXEL_BITS=16)
REQ-034 Seed 0x0001, stop 0x000F, start, send 0x0003,0x0007,0x000F -> DONE, word_cnt 3, err_cnt 0, pass 1.
REQ-035 Same, send 0x0003,0x0008,0x000F -> err_cnt 1, pass 0; with ERRCAP: err_exp 0x0007, err_act 0x0008.
REQ-036 Seed = stop = 0x1234, start -> DONE next cycle, word_cnt 0, pass 1.
REQ-037 Start, send 0x0003, drop chk_en_i with valid 0x0007 -> IDLE, word_cnt 1, exp reloads seed.
REQ-038 Reset asserted in RUN after 2 words -> all outputs 0, seed/stop readback 0x0000.
REQ-039 config_rdy_i=1, config_i=1, data 0xBEEF -> config_done_o 1 next cycle, readback 0xBEEF with config_i=1.

Source files
------------

// File: rtl/lfsr_checker_pkg.sv
// Shared parameters for the LFSR checker: default word width, feedback taps, FSM state type.
package lfsr_checker_pkg;

  localparam int unsigned DefMaxPixelBits = 16;

  // Feedback taps of next(x) = {x[W-2:0], ~(x[TapHi] ^ x[TapLo])}
  localparam int unsigned TapHi = 12;
  localparam int unsigned TapLo = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } chk_state_e;

endpackage

// File: rtl/lfsr_chk_cfg.sv
// Seed/stop configuration registers with write acknowledge and readback mux.
module lfsr_chk_cfg
  import lfsr_checker_pkg::*;
#(
  parameter int unsigned MAX_PIXEL_BITS = DefMaxPixelBits
) (
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      config_i,
  input  logic                      config_rdy_i,
  input  logic [MAX_PIXEL_BITS-1:0] config_data_i,
  output logic                      config_done_o,
  output logic [MAX_PIXEL_BITS-1:0] config_data_o,
  output logic [MAX_PIXEL_BITS-1:0] seed_o,
  output logic [MAX_PIXEL_BITS-1:0] stop_o
);

  logic [MAX_PIXEL_BITS-1:0] seed_q;
  logic [MAX_PIXEL_BITS-1:0] stop_q;
  logic                      done_q;

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      seed_q <= '0;
      stop_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= config_rdy_i;
      if (config_rdy_i) begin
        if (config_i) begin
          stop_q <= config_data_i;
        end else begin
          seed_q <= config_data_i;
        end
      end
    end
  end

  assign config_done_o = done_q;
  assign config_data_o = config_i ? stop_q : seed_q;
  assign seed_o        = seed_q;
  assign stop_o        = stop_q;

endmodule

// File: rtl/lfsr_checker.sv
// Checks a received LFSR word stream against the locally generated sequence from seed to stop.
// Optional first-mismatch capture ports are enabled by defining LFSR_CHK_ERRCAP_EN.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int unsigned MAX_PIXEL_BITS = DefMaxPixelBits,  // must be >= 13
  parameter int unsigned CNT_W          = 16
) (
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      config_i,
  input  logic                      config_rdy_i,
  input  logic [MAX_PIXEL_BITS-1:0] config_data_i,
  output logic                      config_done_o,
  output logic [MAX_PIXEL_BITS-1:0] config_data_o,
  input  logic                      chk_en_i,
  input  logic                      data_vld_i,
  input  logic [MAX_PIXEL_BITS-1:0] data_i,
  output logic                      chk_busy_o,
  output logic                      chk_done_o,
  output logic                      chk_pass_o,
  output logic [CNT_W-1:0]          err_cnt_o,
  output logic [CNT_W-1:0]          word_cnt_o
`ifdef LFSR_CHK_ERRCAP_EN
  ,
  output logic [MAX_PIXEL_BITS-1:0] err_exp_o,
  output logic [MAX_PIXEL_BITS-1:0] err_act_o,
  output logic                      err_seen_o
`endif
);

  function automatic logic [MAX_PIXEL_BITS-1:0] lfsr_next(input logic [MAX_PIXEL_BITS-1:0] x);
    return {x[MAX_PIXEL_BITS-2:0], ~(x[TapHi] ^ x[TapLo])};
  endfunction

  logic [MAX_PIXEL_BITS-1:0] seed;
  logic [MAX_PIXEL_BITS-1:0] stop;

  lfsr_chk_cfg #(
    .MAX_PIXEL_BITS(MAX_PIXEL_BITS)
  ) u_cfg (
    .clk_i        (clk_i),
    .nreset_i     (nreset_i),
    .config_i     (config_i),
    .config_rdy_i (config_rdy_i),
    .config_data_i(config_data_i),
    .config_done_o(config_done_o),
    .config_data_o(config_data_o),
    .seed_o       (seed),
    .stop_o       (stop)
  );

  chk_state_e                state_q, state_d;
  logic [MAX_PIXEL_BITS-1:0] exp_q, exp_d;
  logic [CNT_W-1:0]          err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]          word_cnt_q, word_cnt_d;
  logic                      busy_q, done_q, pass_q;
  logic                      start;
  logic                      accept;
  logic                      mismatch;

  assign start    = (state_q == StIdle) && chk_en_i;
  // Abort wins over a same-cycle valid word, so only accept while enable is held.
  assign accept   = (state_q == StRun) && chk_en_i && data_vld_i;
  assign mismatch = data_i != exp_q;

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    unique case (state_q)
      StIdle: begin
        exp_d = seed;
        if (chk_en_i) begin
          err_cnt_d  = '0;
          word_cnt_d = '0;
          if (seed == stop) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            exp_d   = lfsr_next(seed);
          end
        end
      end
      StRun: begin
        if (!chk_en_i) begin
          state_d = StIdle;
          exp_d   = seed;
        end else if (data_vld_i) begin
          if (mismatch && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          if (word_cnt_q != '1) begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
          exp_d = lfsr_next(exp_q);
          // Termination keys off the expected value, not the received word.
          if (exp_q == stop) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (!chk_en_i) begin
          state_d = StIdle;
          exp_d   = seed;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q    <= StIdle;
      exp_q      <= '0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
      busy_q     <= state_d == StRun;
      done_q     <= state_d == StDone;
      pass_q     <= (state_d == StDone) && (err_cnt_d == '0);
    end
  end

  assign chk_busy_o = busy_q;
  assign chk_done_o = done_q;
  assign chk_pass_o = pass_q;
  assign err_cnt_o  = err_cnt_q;
  assign word_cnt_o = word_cnt_q;

`ifdef LFSR_CHK_ERRCAP_EN
  logic [MAX_PIXEL_BITS-1:0] err_exp_q, err_exp_d;
  logic [MAX_PIXEL_BITS-1:0] err_act_q, err_act_d;
  logic                      err_seen_q, err_seen_d;

  always_comb begin
    err_exp_d  = err_exp_q;
    err_act_d  = err_act_q;
    err_seen_d = err_seen_q;
    if (start) begin
      err_exp_d  = '0;
      err_act_d  = '0;
      err_seen_d = 1'b0;
    end else if (accept && mismatch && !err_seen_q) begin
      err_exp_d  = exp_q;
      err_act_d  = data_i;
      err_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      err_exp_q  <= '0;
      err_act_q  <= '0;
      err_seen_q <= 1'b0;
    end else begin
      err_exp_q  <= err_exp_d;
      err_act_q  <= err_act_d;
      err_seen_q <= err_seen_d;
    end
  end

  assign err_exp_o  = err_exp_q;
  assign err_act_o  = err_act_q;
  assign err_seen_o = err_seen_q;
`else
  logic unused_accept;
  assign unused_accept = accept ^ start;
`endif

endmodule
